// File: rtl/conv_tap_sequencer_if.sv
// Port bundle between the convolution tap sequencer and its environment
// (sample/kernel RAMs, product unit and the y consumer).
interface conv_tap_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int ADDR_W = 6
);
    logic              start;
    logic [ADDR_W:0]   x_len;
    logic [ADDR_W:0]   h_len;
    logic [ADDR_W-1:0] x_addr;
    logic [DATA_W-1:0] x_data;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_data;
    logic [DATA_W-1:0] mul_a;
    logic [DATA_W-1:0] mul_b;
    logic [PROD_W-1:0] mul_p;
    logic              y_valid;
    logic [ACC_W-1:0]  y_data;
    logic [ADDR_W:0]   y_index;
    logic              busy;
    logic              done;

    modport master (
        input  start, x_len, h_len, x_data, h_data, mul_p,
        output x_addr, h_addr, mul_a, mul_b, y_valid, y_data, y_index, busy, done
    );

    modport slave (
        output start, x_len, h_len, x_data, h_data, mul_p,
        input  x_addr, h_addr, mul_a, mul_b, y_valid, y_data, y_index, busy, done
    );
endinterface

// File: rtl/conv_tap_sequencer.sv
// Full linear convolution sequencer: walks (n,k) taps one per clock, feeds the
// product unit through a registered operand stage and accumulates one y per n.
module conv_tap_sequencer #(
    parameter int DATA_W = 16,
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int ADDR_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_tap_sequencer_if.master bus
);
    localparam int CW = ADDR_W + 2;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t            state_r, state_s;
    logic [CW-1:0]     n_r, k_r, nlen_r, mlen_r;
    logic [CW-1:0]     n_nx_s, k_nx_s, kmin_s, kmax_s, x_len_s, h_len_s;
    logic              first_s, last_s, end_s;
    logic              accept_s, zero_s, go_s, issue_s;
    logic [ADDR_W-1:0] x_addr_r, h_addr_r;
    logic              d_v_r, d_first_r, d_last_r, d_end_r;
    logic [ADDR_W:0]   d_n_r;
    logic              op_v_r, op_first_r, op_last_r, op_end_r;
    logic [ADDR_W:0]   op_n_r;
    logic [DATA_W-1:0] mul_a_r, mul_b_r;
    logic [PROD_W-1:0] prod_s;
    logic [ACC_W-1:0]  acc_r, acc_s, y_data_r;
    logic [ADDR_W:0]   y_index_r;
    logic              y_valid_r, done_r, busy_r;

    function automatic logic [CW-1:0] clamp_len(input logic [ADDR_W:0] len);
        logic [CW-1:0] ext;
        logic [CW-1:0] lim;
        ext = {1'b0, len};
        lim = CW'(1) << ADDR_W;
        if (ext > lim) begin
            return lim;
        end else begin
            return ext;
        end
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; DRAIN ends as the final tap is accumulated
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (go_s) state_s = RUN; else state_s = IDLE;
            RUN:     if (end_s) state_s = DRAIN; else state_s = RUN;
            DRAIN:   if (op_v_r && op_end_r) state_s = IDLE; else state_s = DRAIN;
            default: state_s = IDLE;
        endcase
    end

    // Output/control decode of the FSM
    always_comb begin
        x_len_s  = clamp_len(bus.x_len);
        h_len_s  = clamp_len(bus.h_len);
        accept_s = (state_r == IDLE) && bus.start;
        zero_s   = (x_len_s == {CW{1'b0}}) || (h_len_s == {CW{1'b0}});
        go_s     = accept_s && !zero_s;
        issue_s  = (state_r == RUN);
    end

    // Tap walker: valid k range for the current n and the following tap
    always_comb begin
        if (n_r + CW'(1) > nlen_r) kmin_s = n_r + CW'(1) - nlen_r;
        else                       kmin_s = {CW{1'b0}};
        if (n_r + CW'(1) < mlen_r) kmax_s = n_r;
        else                       kmax_s = mlen_r - CW'(1);
        first_s = (k_r == kmin_s);
        last_s  = (k_r == kmax_s);
        end_s   = last_s && (n_r == nlen_r + mlen_r - CW'(2));
        if (last_s) begin
            n_nx_s = n_r + CW'(1);
            if (n_r + CW'(2) > nlen_r) k_nx_s = n_r + CW'(2) - nlen_r;
            else                       k_nx_s = {CW{1'b0}};
        end else begin
            n_nx_s = n_r;
            k_nx_s = k_r + CW'(1);
        end
    end

    // Issue stage: latched lengths, tap counters and RAM addresses
    always_ff @(posedge clk) begin
        if (rst) begin
            nlen_r   <= {CW{1'b0}};
            mlen_r   <= {CW{1'b0}};
            n_r      <= {CW{1'b0}};
            k_r      <= {CW{1'b0}};
            x_addr_r <= {ADDR_W{1'b0}};
            h_addr_r <= {ADDR_W{1'b0}};
        end else begin
            if (accept_s) begin
                nlen_r <= x_len_s;
                mlen_r <= h_len_s;
            end
            if (go_s) begin
                n_r      <= {CW{1'b0}};
                k_r      <= {CW{1'b0}};
                x_addr_r <= {ADDR_W{1'b0}};
                h_addr_r <= {ADDR_W{1'b0}};
            end else if (issue_s && !end_s) begin
                n_r      <= n_nx_s;
                k_r      <= k_nx_s;
                x_addr_r <= ADDR_W'(n_nx_s - k_nx_s);
                h_addr_r <= ADDR_W'(k_nx_s);
            end
        end
    end

    // Accumulate the current product, restarting on the first tap of an n
    always_comb begin
        prod_s = bus.mul_p;
        if (op_first_r) acc_s = ACC_W'(prod_s);
        else            acc_s = acc_r + ACC_W'(prod_s);
    end

    // Tag pipeline, operand registers, accumulator and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            d_v_r      <= 1'b0;
            d_first_r  <= 1'b0;
            d_last_r   <= 1'b0;
            d_end_r    <= 1'b0;
            d_n_r      <= {(ADDR_W+1){1'b0}};
            op_v_r     <= 1'b0;
            op_first_r <= 1'b0;
            op_last_r  <= 1'b0;
            op_end_r   <= 1'b0;
            op_n_r     <= {(ADDR_W+1){1'b0}};
            mul_a_r    <= {DATA_W{1'b0}};
            mul_b_r    <= {DATA_W{1'b0}};
            acc_r      <= {ACC_W{1'b0}};
            y_data_r   <= {ACC_W{1'b0}};
            y_index_r  <= {(ADDR_W+1){1'b0}};
            y_valid_r  <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            d_v_r      <= issue_s;
            d_first_r  <= first_s;
            d_last_r   <= last_s;
            d_end_r    <= end_s;
            d_n_r      <= n_r[ADDR_W:0];
            op_v_r     <= d_v_r;
            op_first_r <= d_first_r;
            op_last_r  <= d_last_r;
            op_end_r   <= d_end_r;
            op_n_r     <= d_n_r;
            if (d_v_r) begin
                mul_a_r <= bus.x_data;
                mul_b_r <= bus.h_data;
            end
            if (op_v_r) begin
                acc_r <= acc_s;
                if (op_last_r) begin
                    y_data_r  <= acc_s;
                    y_index_r <= op_n_r;
                end
            end
            y_valid_r <= op_v_r && op_last_r;
            // Zero-length runs complete immediately without touching the datapath
            done_r    <= (op_v_r && op_end_r) || (accept_s && zero_s);
            if (go_s)        busy_r <= 1'b1;
            else if (done_r) busy_r <= 1'b0;
        end
    end

    assign bus.x_addr  = x_addr_r;
    assign bus.h_addr  = h_addr_r;
    assign bus.mul_a   = mul_a_r;
    assign bus.mul_b   = mul_b_r;
    assign bus.y_valid = y_valid_r;
    assign bus.y_data  = y_data_r;
    assign bus.y_index = y_index_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
endmodule
